cfs_sync_debounce: RTL
======================

Name: cfs_sync_debounce

Overview:
- Input conditioning stage that sits directly upstream of the edge detector.
- Synchronises an asynchronous level input into the `clk` domain through a configurable flop chain, then debounces it: a new level is only accepted once it has been stable for a programmable number of cycles.
- Outputs a clean level `data_out` (feeds the edge detector's data input) plus a one-cycle `changed` pulse on each accepted transition.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops (legal range 2..4).
- CNT_WIDTH, 8, width of the debounce counter and the `threshold` input.
- RESET_VAL, 0, reset value of all synchroniser flops and of `data_out`.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous active-low reset.
- async_in  input  1  raw asynchronous level (pin, switch, external strobe).
- threshold  input  CNT_WIDTH  debounce length in cycles; quasi-static; 0 is treated as 1.
- data_out  output  1  debounced, synchronised level (registered).
- changed  output  1  one-cycle pulse, high in the same cycle `data_out` takes a new value (registered).

Behaviour:
- Clocking and reset:
  - Single clock `clk`.
  - Reset is asynchronous, active-low on `reset_n`.
  - During reset: sync chain = RESET_VAL, `data_out` = RESET_VAL, `changed` = 0, state = STABLE, cnt = 0.
  - No `changed` pulse is produced by reset assertion or release.
- Synchroniser:
  - `async_in` goes through SYNC_STAGES flops.
  - `sync_in` is the last stage.
  - No logic between the stages.
- Definitions:
  - T = (threshold == 0) ? 1 : threshold.
  - `mismatch` = (`sync_in` != `data_out`).
- FSM states: STABLE, CHECK.
- STABLE:
  - `mismatch` = 1 → go to CHECK, cnt <= 1.
  - Otherwise stay, cnt <= 0.
- CHECK:
  - `mismatch` = 0 → glitch rejected; go to STABLE, cnt <= 0, `data_out` unchanged.
  - `mismatch` = 1 and cnt >= T → `data_out` <= `sync_in`, `changed` <= 1, go to STABLE, cnt <= 0.
  - `mismatch` = 1 and cnt < T → cnt <= cnt + 1.
- Pulse width: `changed` is 0 in every cycle other than the commit cycle.
- Latency:
  - Let edge k be the first edge at which a level change on `async_in` is sampled into stage 1, with the level then held.
  - `data_out` changes at edge k + SYNC_STAGES + T.
  - Example: SYNC_STAGES=2, T=3 → edge k+5.
- Stability requirement: `sync_in` must present the new level on T+1 consecutive edges, the first being the edge that enters CHECK. Any single-cycle return to the old level restarts qualification from zero.
- Counter width:
  - cnt is CNT_WIDTH bits. cnt can never exceed T, so it never wraps.
  - threshold = all-ones is legal and gives the maximum debounce.
- Threshold changed mid-CHECK:
  - The comparison always uses the current T.
  - If T is lowered to or below cnt, the commit happens at the next edge where `mismatch` = 1.
- Reset mid-CHECK: pending transition discarded, outputs return to reset values immediately.
- Back-to-back transitions: after a commit, a new change needs a full T+1 qualification again. Minimum spacing between `changed` pulses is T+1 cycles.

Optional Feature:
- Macro: CFS_SYNC_DEBOUNCE_GLITCH_CNT_EN.
- When defined, two extra ports are added:
  - glitch_clr  input  1  synchronous clear.
  - glitch_cnt  output  16  count of rejected glitches.
- Counting rules:
  - glitch_cnt increments by 1 on every CHECK → STABLE exit caused by `mismatch` = 0.
  - Saturates at 16'hFFFF.
  - Reset value 0.
  - glitch_clr = 1 forces 0 on the next edge and has priority over an increment in the same cycle.
  - Registered output, updated on the same edge as the FSM transition.
- When not defined: ports, counter and logic are absent; all other behaviour is identical.

Test Plan:
- Reset release: RESET_VAL=0, async_in=0, reset_n rises → data_out=0, changed=0 for 20 cycles.
- Clean rise: SYNC_STAGES=2, threshold=3, async_in 0→1 sampled at edge k and held → data_out=1 and changed=1 at edge k+5 only; changed=0 at k+6.
- Glitch rejection: threshold=4, async_in high for 3 cycles then low → data_out stays 0, changed never pulses; with macro defined, glitch_cnt=1.
- Threshold zero: threshold=0, async_in 0→1 held → data_out=1 at edge k+3, identical to threshold=1.
- Reset mid-CHECK: threshold=10, async_in 0→1, reset_n low 5 cycles later → data_out=0 immediately, changed=0, no commit after release while async_in=0.
- Saturation/clear (macro defined): force glitch_cnt to 16'hFFFF via repeated glitches (or preload in sim), one more glitch → stays 16'hFFFF; glitch_clr with a simultaneous glitch → 0.

Source files
------------

// File: rtl/cfs_sync_debounce.sv
// rtl/cfs_sync_debounce.sv - synchroniser plus level debouncer with change pulse
// Optional rejected-glitch counter: define CFS_SYNC_DEBOUNCE_GLITCH_CNT_EN.
module cfs_sync_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 8,
    parameter bit RESET_VAL   = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 async_in,
    input  logic [CNT_WIDTH-1:0] threshold,
`ifdef CFS_SYNC_DEBOUNCE_GLITCH_CNT_EN
    input  logic                 glitch_clr,
    output logic [15:0]          glitch_cnt,
`endif
    output logic                 data_out,
    output logic                 changed
);

    typedef enum logic {STABLE, CHECK} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_in;
    logic                   mismatch;
    logic [CNT_WIDTH-1:0]   thr_eff;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   data_d;
    logic                   changed_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_in  = sync_q[SYNC_STAGES-1];
    assign mismatch = (sync_in != data_out);
    // A zero threshold behaves exactly like one so a commit always needs two matching samples.
    assign thr_eff  = (threshold == '0) ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} : threshold;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= STABLE;
            cnt_q    <= '0;
            data_out <= RESET_VAL;
            changed  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_out <= data_d;
            changed  <= changed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_out;
        changed_d = 1'b0;
        case (state_q)
            STABLE: begin
                if (mismatch) begin
                    state_d = CHECK;
                    cnt_d   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    cnt_d   = '0;
                end
            end
            CHECK: begin
                if (!mismatch) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q >= thr_eff) begin
                    state_d   = STABLE;
                    cnt_d     = '0;
                    data_d    = sync_in;
                    changed_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef CFS_SYNC_DEBOUNCE_GLITCH_CNT_EN
    logic glitch_evt;

    assign glitch_evt = (state_q == CHECK) && !mismatch;

    // Clear wins over a same-cycle glitch; the count sticks at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            glitch_cnt <= 16'h0000;
        end else if (glitch_clr) begin
            glitch_cnt <= 16'h0000;
        end else if (glitch_evt && (glitch_cnt != 16'hFFFF)) begin
            glitch_cnt <= glitch_cnt + 16'd1;
        end
    end
`endif

endmodule
